// File: rtl/ms_timer_pkg.sv
// Shared definitions for the millisecond timer scheduler: arbiter state
// encoding and the default 50 MHz -> 1 ms prescale ratio.
package ms_timer_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int CLK_DIV_50MHZ_1MS = 50000;

endpackage

// File: rtl/ms_timer_sched_if.sv
// CPU-facing bus of the timer scheduler: channel write port plus the
// interrupt request / ID / acknowledge handshake.
interface ms_timer_sched_if #(
    parameter int IDW = 2,
    parameter int CW  = 16
);
    logic           wr_en;
    logic [IDW-1:0] wr_ch;
    logic [CW-1:0]  wr_load;
    logic           wr_periodic;
    logic           irq;
    logic [IDW-1:0] irq_ch;
    logic           irq_ack;

    modport master (
        output wr_en, wr_ch, wr_load, wr_periodic, irq_ack,
        input  irq, irq_ch
    );

    modport slave (
        input  wr_en, wr_ch, wr_load, wr_periodic, irq_ack,
        output irq, irq_ch
    );
endinterface

// File: rtl/ms_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 and emits a registered one-cycle tick on
// each wrap, so the first tick lands CLK_DIV cycles after reset.
module ms_tick_gen
    import ms_timer_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_50MHZ_1MS
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == PW'(CLK_DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/ms_timer_sched.sv
// Multi-channel 1 ms countdown timers with round-robin expiry arbitration
// onto a single acknowledged interrupt line.
module ms_timer_sched
    import ms_timer_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_50MHZ_1MS,
    parameter int NCH     = 4,
    parameter int CW      = 16,
    parameter int IDW     = 2
) (
    input  logic             clk,
    input  logic             reset,
    ms_timer_sched_if.slave  bus,
    output logic             tick_1ms,
    output logic [NCH-1:0]   active,
    output logic [NCH-1:0]   overrun
);
    logic [NCH-1:0] pend_vec;
    logic [NCH-1:0] clr;

    ms_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_1ms)
    );

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CW-1:0] load_q, load_d, cnt_q, cnt_d;
        logic          per_q, per_d, act_q, act_d;
        logic          pend_q, pend_d, ovr_q, ovr_d;
        logic          wr_hit, expire;

        always_comb begin
            wr_hit = bus.wr_en && (bus.wr_ch == IDW'(c));
            // A write on the same cycle discards the expiry entirely.
            expire = tick_1ms && act_q && (cnt_q == CW'(1)) && !wr_hit;
            load_d = load_q;
            cnt_d  = cnt_q;
            per_d  = per_q;
            act_d  = act_q;
            ovr_d  = ovr_q;
            // Expiry beats a simultaneous acknowledge so the event is not lost.
            pend_d = expire ? 1'b1 : (clr[c] ? 1'b0 : pend_q);
            if (wr_hit) begin
                ovr_d = 1'b0;
                if (bus.wr_load != '0) begin
                    load_d = bus.wr_load;
                    cnt_d  = bus.wr_load;
                    act_d  = 1'b1;
                    per_d  = bus.wr_periodic;
                end else begin
                    act_d = 1'b0;
                    cnt_d = '0;
                end
            end else if (tick_1ms && act_q) begin
                if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (expire) begin
                    if (pend_q && !clr[c]) ovr_d = 1'b1;
                    if (per_q) begin
                        cnt_d = load_q;
                    end else begin
                        cnt_d = '0;
                        act_d = 1'b0;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                load_q <= '0;
                cnt_q  <= '0;
                per_q  <= 1'b0;
                act_q  <= 1'b0;
                pend_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else begin
                load_q <= load_d;
                cnt_q  <= cnt_d;
                per_q  <= per_d;
                act_q  <= act_d;
                pend_q <= pend_d;
                ovr_q  <= ovr_d;
            end
        end

        assign pend_vec[c] = pend_q;
        assign active[c]   = act_q;
        assign overrun[c]  = ovr_q;
    end

    // Returns {found, index} of the first request at or after last+1, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [NCH-1:0] req,
                                             input logic [IDW-1:0] last);
        logic [IDW:0] r;
        int           idx;
        r = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last) + i) % NCH;
            if (req[idx] && !r[IDW]) r = {1'b1, IDW'(idx)};
        end
        return r;
    endfunction

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] irq_ch_q, irq_ch_d, last_q, last_d;
    logic [IDW:0]   pick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            irq_ch_q <= '0;
            last_q   <= IDW'(NCH - 1);
        end else begin
            state_q  <= state_d;
            irq_ch_q <= irq_ch_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        pick     = rr_pick(pend_vec, last_q);
        state_d  = state_q;
        irq_ch_d = irq_ch_q;
        last_d   = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick[IDW]) begin
                    irq_ch_d = pick[IDW-1:0];
                    state_d  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (bus.irq_ack) begin
                    last_d  = irq_ch_q;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        if (state_q == ARB_GRANT && bus.irq_ack) clr[irq_ch_q] = 1'b1;
    end

    assign bus.irq    = (state_q == ARB_GRANT);
    assign bus.irq_ch = irq_ch_q;
endmodule

// File: tb/tb_ms_timer_sched.sv
// Directed bench for ms_timer_sched at CLK_DIV=4; cycle numbers in comments
// count rising edges since the most recent reset release.
module tb_ms_timer_sched;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           tick_1ms;
    logic [NCH-1:0] active;
    logic [NCH-1:0] overrun;
    int             checks = 0;
    int             errors = 0;

    ms_timer_sched_if #(.IDW(IDW), .CW(CW)) bus ();

    ms_timer_sched #(.CLK_DIV(4), .NCH(NCH), .CW(CW), .IDW(IDW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tick_1ms (tick_1ms),
        .active   (active),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int load, input bit per);
        bus.wr_en       = 1'b1;
        bus.wr_ch       = IDW'(ch);
        bus.wr_load     = CW'(load);
        bus.wr_periodic = per;
        step();
        bus.wr_en       = 1'b0;
    endtask

    // Counts the current cycle too; returns in the cycle of the n-th tick.
    task automatic ticks_from_here(input int n);
        int k = 0;
        int g = 0;
        forever begin
            if (tick_1ms) k++;
            if (k >= n || g > 200) break;
            step();
            g++;
        end
        if (k < n) chk("tick_wait", k, n);
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk("ack_drop", bus.irq, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi;
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_load = '0;
        bus.wr_periodic = 1'b0; bus.irq_ack = 1'b0;

        // reset state
        do_reset();
        chk("rst_irq", bus.irq, 0);
        chk("rst_irq_ch", bus.irq_ch, 0);
        chk("rst_tick", tick_1ms, 0);
        chk("rst_active", active, 0);
        chk("rst_overrun", overrun, 0);

        // tick cadence: high only in cycles 4,8,12,16,20
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("cadence", tick_1ms, (k % 4 == 0));
            if (k < 4) chk("pre_tick_irq", bus.irq, 0);
        end

        // one-shot ch1 L=3 written in tick cycle 20: ticks 24,28,32
        wr(1, 3, 1'b0);
        chk("os_active", active[1], 1);
        ticks_from_here(3);
        chk("os_t_irq", bus.irq, 0);
        step();
        chk("os_t1_irq", bus.irq, 0);
        chk("os_t1_active", active[1], 0);
        step();
        chk("os_irq", bus.irq, 1);
        chk("os_irq_ch", bus.irq_ch, 1);
        ack();
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.irq) hi++;
        end
        chk("os_no_reirq", hi, 0);

        // periodic ch0 L=1, never acknowledged
        wr(0, 1, 1'b1);
        ticks_from_here(1);
        step();
        step();
        chk("per_irq", bus.irq, 1);
        chk("per_irq_ch", bus.irq_ch, 0);
        chk("per_ovr_first", overrun[0], 0);
        step();
        ticks_from_here(1);
        chk("per_ovr_at_tick2", overrun[0], 0);
        step();
        chk("per_ovr_set", overrun[0], 1);
        chk("per_irq_held", bus.irq, 1);
        chk("per_irq_ch_held", bus.irq_ch, 0);
        wr(0, 1, 1'b1);
        chk("per_ovr_cleared", overrun[0], 0);
        wr(0, 0, 1'b0);
        chk("per_stopped", active[0], 0);
        chk("per_stop_ovr", overrun[0], 0);
        ack();
        step();
        step();
        chk("per_quiet", bus.irq, 0);

        // round robin from reset (last_grant = 3): ch0,2,3 expire at cycle 8
        do_reset();
        wr(0, 2, 1'b0);
        wr(2, 2, 1'b0);
        wr(3, 2, 1'b0);
        ticks_from_here(2);
        step();
        step();
        chk("rr1_irq", bus.irq, 1);
        chk("rr1_ch_a", bus.irq_ch, 0);
        ack();
        step();
        chk("rr1_irq_b", bus.irq, 1);
        chk("rr1_ch_b", bus.irq_ch, 2);
        ack();
        step();
        chk("rr1_irq_c", bus.irq, 1);
        chk("rr1_ch_c", bus.irq_ch, 3);
        ack();
        step();
        chk("rr1_done", bus.irq, 0);

        // ch2 alone so last_grant = 2, then ch0+ch3 together: 3 wins, then 0
        wr(2, 1, 1'b0);
        ticks_from_here(1);
        step();
        step();
        chk("rr_ch2", bus.irq_ch, 2);
        ack();
        ticks_from_here(1);
        wr(0, 2, 1'b0);
        wr(3, 2, 1'b0);
        ticks_from_here(2);
        step();
        step();
        chk("rr2_irq", bus.irq, 1);
        chk("rr2_ch_a", bus.irq_ch, 3);
        ack();
        step();
        chk("rr2_irq_b", bus.irq, 1);
        chk("rr2_ch_b", bus.irq_ch, 0);
        ack();

        // write wins over expiry: ch2 cnt==1 on a tick, rewritten with L=3
        ticks_from_here(1);
        wr(2, 1, 1'b0);
        ticks_from_here(1);
        wr(2, 3, 1'b0);
        step();
        chk("col_wr_no_pend", bus.irq, 0);
        ticks_from_here(3);
        chk("col_wr_t3_irq", bus.irq, 0);
        step();
        chk("col_wr_t3p1_irq", bus.irq, 0);
        step();
        chk("col_wr_irq", bus.irq, 1);
        chk("col_wr_ch", bus.irq_ch, 2);
        ack();

        // ack collides with re-expiry of the granted channel
        ticks_from_here(1);
        wr(1, 1, 1'b1);
        ticks_from_here(1);
        step();
        step();
        chk("col_ack_irq", bus.irq, 1);
        chk("col_ack_ch", bus.irq_ch, 1);
        step();
        step();
        chk("col_ack_tick", tick_1ms, 1);
        ack();
        chk("col_ack_ovr", overrun[1], 0);
        step();
        chk("col_ack_reirq", bus.irq, 1);
        chk("col_ack_reirq_ch", bus.irq_ch, 1);
        chk("col_ack_ovr2", overrun[1], 0);
        wr(1, 0, 1'b0);
        ack();

        // reset while a grant is outstanding and channels run
        wr(0, 1, 1'b1);
        wr(3, 5, 1'b1);
        ticks_from_here(1);
        step();
        step();
        chk("mid_irq", bus.irq, 1);
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_irq", bus.irq, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_tick", tick_1ms, 0);
        chk("mid_rst_irq_ch", bus.irq_ch, 0);
        reset = 1'b0;
        hi = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("mid_cadence", tick_1ms, (k % 4 == 0));
            if (bus.irq) hi++;
        end
        chk("mid_no_irq", hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
